psram_qpi_model: RTL and testbench



---
 rtl/psram_qpi_model.sv | 165 ++++++++++++++++
 tb/tb_psram_qpi_model.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_model.sv
// Behavioural QSPI/QPI pseudo-static RAM for SoC simulation: quad read/write,
// QPI command mode, sticky error flag and asynchronous abort on ce_n.
module psram_qpi_model #(
  parameter int ADDR_W    = 24,
  parameter int READ_WAIT = 6
) (
  input  logic       reset,
  input  logic       sck,
  input  logic       ce_n,
  inout  wire  [3:0] dio,
  output logic       qpi_mode,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, WDATA, RDATA, ERR} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [23:0]  addr_q, addr_d;
  logic [3:0]   nib_q, nib_d;
  logic         half_q, half_d;
  logic         done_q, done_d;
  logic         qpi_q, qpi_d;
  logic         err_q, err_d;
  logic         oe_q;
  logic [3:0]   dout_q;
  logic         memWe;
  logic [7:0]   cmdNext;
  logic [ADDR_W-1:0] memIdx;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  assign memIdx   = addr_q[ADDR_W-1:0];
  assign cmdNext  = qpi_q ? {cmd_q[3:0], dio} : {cmd_q[6:0], dio[0]};
  assign dio      = oe_q ? dout_q : 4'bz;
  assign qpi_mode = qpi_q;
  assign err      = err_q;

  // ce_n high acts as an asynchronous clear of the whole transaction context.
  always_ff @(posedge sck or posedge reset or posedge ce_n) begin
    if (reset || ce_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      nib_q   <= '0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      nib_q   <= nib_d;
      half_q  <= half_d;
      done_q  <= done_d;
    end
  end

  // Mode and error flags survive ce_n aborts; only reset clears them.
  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      qpi_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      qpi_q <= qpi_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    nib_d   = nib_q;
    half_d  = half_q;
    done_d  = done_q;
    qpi_d   = qpi_q;
    err_d   = err_q;
    memWe   = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q blocks a second command after a mode switch until ce_n rises.
        if (!done_q && !ce_n) begin
          cmd_d   = cmdNext;
          cnt_d   = 4'd1;
          state_d = CMD;
        end
      end
      CMD: begin
        cmd_d = cmdNext;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == (qpi_q ? 4'd1 : 4'd7)) begin
          cnt_d = '0;
          case (cmdNext)
            8'hEB, 8'h38: state_d = ADDR;
            8'h35: begin
              qpi_d   = 1'b1;
              done_d  = 1'b1;
              state_d = IDLE;
            end
            8'hF5: begin
              qpi_d   = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          endcase
        end
      end
      ADDR: begin
        addr_d = {addr_q[19:0], dio};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd5) begin
          cnt_d   = '0;
          half_d  = 1'b0;
          state_d = (cmd_q == 8'h38) ? WDATA : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(READ_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (!half_q) begin
          nib_d  = dio;
          half_d = 1'b1;
        end else begin
          memWe  = 1'b1;
          half_d = 1'b0;
          addr_d = addr_q + 24'd1;
        end
      end
      RDATA: begin
        half_d = ~half_q;
        if (half_q) addr_d = addr_q + 24'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sck) begin
    if (memWe) mem[memIdx] <= {nib_q, dio};
  end

  // Read data launches on the falling edge so the master samples it on the rising edge.
  always_ff @(negedge sck or posedge reset or posedge ce_n) begin
    if (reset || ce_n) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else if (state_q == RDATA) begin
      oe_q   <= 1'b1;
      dout_q <= half_q ? mem[memIdx][3:0] : mem[memIdx][7:4];
    end
  end

endmodule

// File: tb/tb_psram_qpi_model.sv
// Scoreboard bench for psram_qpi_model: directed scenarios plus random traffic
// checked against an associative-array memory model.
module tb_psram_qpi_model;

  localparam int ADDR_W    = 24;
  localparam int READ_WAIT = 6;
  localparam int KIND_DIO  = 0;
  localparam int KIND_QPI  = 1;
  localparam int KIND_ERR  = 2;
  localparam logic [3:0] ZVAL = 4'hF;

  typedef struct {
    int         kind;
    string      name;
    logic [3:0] val;
  } expT;

  logic       reset;
  logic       sck;
  logic       ce_n;
  logic       qpi_mode;
  logic       err;
  logic       tbOe;
  logic [3:0] tbDout;
  wire  [3:0] dio;

  assign dio = tbOe ? tbDout : 4'bz;
  pullup pu0 (dio[0]);
  pullup pu1 (dio[1]);
  pullup pu2 (dio[2]);
  pullup pu3 (dio[3]);

  psram_qpi_model #(.ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT)) dut (
    .reset    (reset),
    .sck      (sck),
    .ce_n     (ce_n),
    .dio      (dio),
    .qpi_mode (qpi_mode),
    .err      (err)
  );

  logic [7:0]  refMem [int unsigned];
  bit          refQpi;
  bit          refErr;
  expT         expQ[$];
  int          testsRun;
  int          testsFailed;
  logic [23:0] written[$];

  initial begin
    sck = 1'b0;
    forever #5 sck = ~sck;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not end, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: everything queued since the last falling edge is checked just after the rising edge.
  always @(posedge sck) begin
    #1;
    while (expQ.size() > 0) begin
      expT e;
      logic [3:0] act;
      e = expQ.pop_front();
      case (e.kind)
        KIND_QPI: act = {3'b000, qpi_mode};
        KIND_ERR: act = {3'b000, err};
        default:  act = dio;
      endcase
      testsRun++;
      if (act !== e.val) begin
        testsFailed++;
        $display("[TB] FAIL %s: actual=%h required=%h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  function automatic int unsigned idxOf(input logic [23:0] a, input int k);
    longint unsigned s;
    longint unsigned span;
    span = 64'd1 << ADDR_W;
    s    = 64'(a[ADDR_W-1:0]);
    s    = (s + 64'(k)) % span;
    return s[31:0];
  endfunction

  task automatic checkOutput(input int kind, input string name, input logic [3:0] val);
    expT e;
    e.kind = kind;
    e.name = name;
    e.val  = val;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] n);
    @(negedge sck);
    ce_n   = 1'b0;
    tbOe   = 1'b1;
    tbDout = n;
  endtask

  task automatic sendCmd(input logic [7:0] c);
    if (refQpi) begin
      applyStimulus(c[7:4]);
      applyStimulus(c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) applyStimulus({3'b000, c[i]});
    end
  endtask

  task automatic sendAddr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) applyStimulus(a[i*4 +: 4]);
  endtask

  task automatic endTxn();
    @(negedge sck);
    tbOe = 1'b0;
    ce_n = 1'b1;
    checkOutput(KIND_DIO, "idleZ", ZVAL);
    @(negedge sck);
  endtask

  task automatic doMode(input logic [7:0] c);
    sendCmd(c);
    if (c == 8'h35) refQpi = 1'b1;
    else            refQpi = 1'b0;
    endTxn();
    checkOutput(KIND_QPI, "qpiMode", {3'b000, refQpi});
  endtask

  task automatic doWrite(input logic [23:0] a, input logic [7:0] data[$],
                         input bit extraNib, input logic [3:0] nib);
    sendCmd(8'h38);
    sendAddr(a);
    for (int k = 0; k < data.size(); k++) begin
      logic [7:0] b;
      b = data[k];
      applyStimulus(b[7:4]);
      applyStimulus(b[3:0]);
      refMem[idxOf(a, k)] = b;
    end
    if (extraNib) applyStimulus(nib);
    endTxn();
  endtask

  task automatic waitPhase();
    for (int w = 0; w < READ_WAIT; w++) begin
      @(negedge sck);
      tbOe = 1'b0;
      checkOutput(KIND_DIO, "waitZ", ZVAL);
    end
  endtask

  task automatic doRead(input logic [23:0] a, input int n);
    sendCmd(8'hEB);
    sendAddr(a);
    waitPhase();
    for (int k = 0; k < n; k++) begin
      int unsigned idx;
      logic [7:0]  b;
      bit          known;
      idx   = idxOf(a, k);
      known = refMem.exists(idx);
      b     = known ? refMem[idx] : 8'h00;
      @(negedge sck);
      if (known) checkOutput(KIND_DIO, "rdHi", b[7:4]);
      @(negedge sck);
      if (known) checkOutput(KIND_DIO, "rdLo", b[3:0]);
    end
    endTxn();
  endtask

  initial begin
    logic [7:0] d[$];
    testsRun    = 0;
    testsFailed = 0;
    refQpi      = 1'b0;
    refErr      = 1'b0;
    reset       = 1'b1;
    ce_n        = 1'b1;
    tbOe        = 1'b0;
    tbDout      = 4'h0;

    repeat (2) @(negedge sck);
    checkOutput(KIND_DIO, "rstDio", ZVAL);
    checkOutput(KIND_QPI, "rstQpi", 4'h0);
    checkOutput(KIND_ERR, "rstErr", 4'h0);
    @(negedge sck);
    reset = 1'b0;
    repeat (2) @(negedge sck);

    // Basic SPI write then read back with WAIT high-Z
    d = '{8'hA5, 8'h3C};
    doWrite(24'h000010, d, 1'b0, 4'h0);
    doRead(24'h000010, 2);

    // Address wrap at the top of the array
    d = '{8'h11, 8'h22};
    doWrite(24'hFFFFFF, d, 1'b0, 4'h0);
    doRead(24'h000000, 1);
    doRead(24'hFFFFFF, 2);

    // QPI entry, extra clocks after a mode command are ignored, QPI traffic, exit
    sendCmd(8'h35);
    refQpi = 1'b1;
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, 1'(8'h12 >> i)});
    endTxn();
    checkOutput(KIND_QPI, "qpiEnter", 4'h1);
    checkOutput(KIND_ERR, "noErrAfterMode", 4'h0);
    d = '{8'h7E};
    doWrite(24'h000100, d, 1'b0, 4'h0);
    doRead(24'h000100, 1);
    doMode(8'hF5);

    // Unsupported command: sticky error, bus stays released, input ignored
    sendCmd(8'h12);
    refErr = 1'b1;
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, 1'(8'h35 >> i)});
    for (int c = 0; c < 40; c++) begin
      @(negedge sck);
      tbOe = 1'b0;
      checkOutput(KIND_DIO, "errZ", ZVAL);
    end
    endTxn();
    checkOutput(KIND_ERR, "errSet", 4'h1);
    checkOutput(KIND_QPI, "errNoQpi", 4'h0);
    doRead(24'h000010, 2);
    checkOutput(KIND_ERR, "errSticky", 4'h1);

    // Half-written byte is discarded
    d = '{8'h5B};
    doWrite(24'h000021, d, 1'b0, 4'h0);
    d = '{8'h9F};
    doWrite(24'h000020, d, 1'b1, 4'h4);
    doRead(24'h000020, 2);

    // Reset in the middle of a QPI read
    doMode(8'h35);
    d = '{8'hC3, 8'hD4};
    doWrite(24'h000300, d, 1'b0, 4'h0);
    sendCmd(8'hEB);
    sendAddr(24'h000300);
    waitPhase();
    @(negedge sck);
    checkOutput(KIND_DIO, "preRstHi", 4'hC);
    @(negedge sck);
    checkOutput(KIND_DIO, "preRstLo", 4'h3);
    @(negedge sck);
    #1;
    reset  = 1'b1;
    refQpi = 1'b0;
    refErr = 1'b0;
    checkOutput(KIND_DIO, "rstAbortZ", ZVAL);
    checkOutput(KIND_QPI, "rstAbortQpi", 4'h0);
    checkOutput(KIND_ERR, "rstAbortErr", 4'h0);
    @(negedge sck);
    reset = 1'b0;
    ce_n  = 1'b1;
    tbOe  = 1'b0;
    repeat (2) @(negedge sck);
    doRead(24'h000300, 2);
    doRead(24'hFFFFFF, 2);

    // Randomised mix of mode switches, writes and reads
    for (int t = 0; t < 24; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        doMode(refQpi ? 8'hF5 : 8'h35);
      end else if (r <= 4 || written.size() == 0) begin
        logic [23:0] a;
        int n;
        a = 24'($urandom);
        n = int'($urandom_range(1, 4));
        d.delete();
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        doWrite(a, d, 1'b0, 4'h0);
        written.push_back(a);
      end else begin
        int pick;
        pick = int'($urandom_range(0, written.size() - 1));
        doRead(written[pick], int'($urandom_range(1, 4)));
      end
    end
    checkOutput(KIND_QPI, "finalQpi", {3'b000, refQpi});
    checkOutput(KIND_ERR, "finalErr", {3'b000, refErr});

    @(posedge sck);
    #2;
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
